mem_wb_pipe_regs: RTL and testbench

- Implements the EX/MEM and MEM/WB pipeline registers of the five-stage RISC-V core.
- Drives the data-memory port and performs load extraction and store byte-lane steering.
- Produces the write-back data.
- Sources EX_MEM_Rd, EX_MEM_RegWrite, MEM_WB_Rd and MEM_WB_RegWrite, which the forwarding unit consumes directly. Also sources the forwarded operand values EX_MEM_alu_result and MEM_WB_wdata.

---
 rtl/mem_wb_pipe_regs_if.sv | 22 ++
 rtl/mem_wb_pipe_regs.sv | 191 +++++++++++++++++++
 tb/tb_mem_wb_pipe_regs.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_regs_if.sv
// Data-memory port bundle between the MEM stage (master) and the data memory (slave).
interface mem_wb_pipe_regs_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_re;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ready;

  modport master (
    output dmem_addr, dmem_wdata, dmem_be, dmem_re, dmem_we,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_be, dmem_re, dmem_we,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_wb_pipe_regs.sv
// EX/MEM and MEM/WB pipeline registers: data-memory access, load extraction,
// store lane steering, write-back select and retired-instruction counting.
module mem_wb_pipe_regs #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 flush_ex,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic [2:0]           ex_funct3,
  input  logic [1:0]           ex_wb_sel,
  input  logic [XLEN-1:0]      ex_alu_result,
  input  logic [XLEN-1:0]      ex_store_data,
  input  logic [XLEN-1:0]      ex_pc,
  mem_wb_pipe_regs_if.master   dmem,
  output logic                 mem_stall,
  output logic [4:0]           EX_MEM_Rd,
  output logic                 EX_MEM_RegWrite,
  output logic                 EX_MEM_MemRead,
  output logic [XLEN-1:0]      EX_MEM_alu_result,
  output logic [4:0]           MEM_WB_Rd,
  output logic                 MEM_WB_RegWrite,
  output logic [XLEN-1:0]      MEM_WB_wdata,
  output logic [INSTRET_W-1:0] instret
);

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      ofs,
                                                   input logic [2:0]      f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{ofs, 3'b000} +: 8];
    h = word[{ofs[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] ofs);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << ofs;
      2'b01:   store_be = 4'b0011 << {ofs[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0]      f3,
                                                  input logic [XLEN-1:0] sd);
    case (f3[1:0])
      2'b00:   store_lanes = {(XLEN/8){sd[7:0]}};
      2'b01:   store_lanes = {(XLEN/16){sd[15:0]}};
      default: store_lanes = sd;
    endcase
  endfunction

  logic            vld_p1_q, vld_p1_d;
  logic [4:0]      rd_p1_q, rd_p1_d;
  logic            rw_p1_q, rw_p1_d;
  logic            mr_p1_q, mr_p1_d;
  logic            mw_p1_q, mw_p1_d;
  logic [2:0]      f3_p1_q, f3_p1_d;
  logic [1:0]      wbsel_p1_q, wbsel_p1_d;
  logic [XLEN-1:0] alu_p1_q, alu_p1_d;
  logic [XLEN-1:0] sd_p1_q, sd_p1_d;
  logic [XLEN-1:0] pc_p1_q, pc_p1_d;

  logic            vld_p2_q, vld_p2_d;
  logic [4:0]      rd_p2_q, rd_p2_d;
  logic            rw_p2_q, rw_p2_d;
  logic [XLEN-1:0] wdata_p2_q, wdata_p2_d;

  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]      wb_val;

  // MEM stage: memory port driven straight from the EX/MEM registers
  assign dmem.dmem_re    = vld_p1_q & mr_p1_q;
  assign dmem.dmem_we    = vld_p1_q & mw_p1_q;
  assign dmem.dmem_addr  = {alu_p1_q[XLEN-1:2], 2'b00};
  assign dmem.dmem_wdata = store_lanes(f3_p1_q, sd_p1_q);
  assign dmem.dmem_be    = dmem.dmem_we ? store_be(f3_p1_q, alu_p1_q[1:0]) : 4'b0000;
  assign mem_stall       = (dmem.dmem_re | dmem.dmem_we) & ~dmem.dmem_ready;

  always_comb begin
    case (wbsel_p1_q)
      2'b00:   wb_val = alu_p1_q;
      2'b01:   wb_val = load_extract(dmem.dmem_rdata, alu_p1_q[1:0], f3_p1_q);
      2'b10:   wb_val = pc_p1_q + XLEN'(4);
      default: wb_val = '0;
    endcase
  end

  always_comb begin
    vld_p1_d   = vld_p1_q;
    rd_p1_d    = rd_p1_q;
    rw_p1_d    = rw_p1_q;
    mr_p1_d    = mr_p1_q;
    mw_p1_d    = mw_p1_q;
    f3_p1_d    = f3_p1_q;
    wbsel_p1_d = wbsel_p1_q;
    alu_p1_d   = alu_p1_q;
    sd_p1_d    = sd_p1_q;
    pc_p1_d    = pc_p1_q;
    vld_p2_d   = 1'b0;
    rd_p2_d    = 5'd0;
    rw_p2_d    = 1'b0;
    wdata_p2_d = wdata_p2_q;
    instret_d  = instret_q;
    // A stalled MEM access freezes EX/MEM (flush included) and bubbles MEM/WB
    if (!mem_stall) begin
      f3_p1_d    = ex_funct3;
      wbsel_p1_d = ex_wb_sel;
      alu_p1_d   = ex_alu_result;
      sd_p1_d    = ex_store_data;
      pc_p1_d    = ex_pc;
      if (flush_ex || !ex_valid) begin
        vld_p1_d = 1'b0;
        rd_p1_d  = 5'd0;
        rw_p1_d  = 1'b0;
        mr_p1_d  = 1'b0;
        mw_p1_d  = 1'b0;
      end else begin
        vld_p1_d = 1'b1;
        rd_p1_d  = ex_rd;
        rw_p1_d  = ex_reg_write;
        mr_p1_d  = ex_mem_read;
        mw_p1_d  = ex_mem_write;
      end
      vld_p2_d   = vld_p1_q;
      rd_p2_d    = rd_p1_q;
      rw_p2_d    = rw_p1_q;
      wdata_p2_d = wb_val;
      instret_d  = instret_q + INSTRET_W'(vld_p1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      rd_p1_q    <= 5'd0;
      rw_p1_q    <= 1'b0;
      mr_p1_q    <= 1'b0;
      mw_p1_q    <= 1'b0;
      f3_p1_q    <= 3'd0;
      wbsel_p1_q <= 2'd0;
      alu_p1_q   <= '0;
      sd_p1_q    <= '0;
      pc_p1_q    <= '0;
      vld_p2_q   <= 1'b0;
      rd_p2_q    <= 5'd0;
      rw_p2_q    <= 1'b0;
      wdata_p2_q <= '0;
      instret_q  <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      rd_p1_q    <= rd_p1_d;
      rw_p1_q    <= rw_p1_d;
      mr_p1_q    <= mr_p1_d;
      mw_p1_q    <= mw_p1_d;
      f3_p1_q    <= f3_p1_d;
      wbsel_p1_q <= wbsel_p1_d;
      alu_p1_q   <= alu_p1_d;
      sd_p1_q    <= sd_p1_d;
      pc_p1_q    <= pc_p1_d;
      vld_p2_q   <= vld_p2_d;
      rd_p2_q    <= rd_p2_d;
      rw_p2_q    <= rw_p2_d;
      wdata_p2_q <= wdata_p2_d;
      instret_q  <= instret_d;
    end
  end

  // WB stage: qualified outputs seen by the forwarding and hazard units
  assign EX_MEM_Rd         = rd_p1_q;
  assign EX_MEM_RegWrite   = vld_p1_q & rw_p1_q & (rd_p1_q != 5'd0);
  assign EX_MEM_MemRead    = vld_p1_q & mr_p1_q;
  assign EX_MEM_alu_result = alu_p1_q;
  assign MEM_WB_Rd         = rd_p2_q;
  assign MEM_WB_RegWrite   = vld_p2_q & rw_p2_q & (rd_p2_q != 5'd0);
  assign MEM_WB_wdata      = wdata_p2_q;
  assign instret           = instret_q;

endmodule

// File: tb/tb_mem_wb_pipe_regs.sv
// Directed bench for mem_wb_pipe_regs with a write-back scoreboard.
module tb_mem_wb_pipe_regs;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, flush_ex, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu_result, ex_store_data, ex_pc;
  logic        mem_stall, EX_MEM_RegWrite, EX_MEM_MemRead, MEM_WB_RegWrite;
  logic [4:0]  EX_MEM_Rd, MEM_WB_Rd;
  logic [31:0] EX_MEM_alu_result, MEM_WB_wdata, instret;

  mem_wb_pipe_regs_if #(.XLEN(32)) bus ();

  mem_wb_pipe_regs #(.XLEN(32), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush_ex(flush_ex),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_wb_sel(ex_wb_sel),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .dmem(bus), .mem_stall(mem_stall), .EX_MEM_Rd(EX_MEM_Rd),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
    .EX_MEM_alu_result(EX_MEM_alu_result), .MEM_WB_Rd(MEM_WB_Rd),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_wdata(MEM_WB_wdata), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] wdata;
  } wb_t;

  wb_t         sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] prev_instret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic [31:0] wd);
    wb_t e;
    e.rd = rd; e.rw = rw; e.wdata = wd;
    sb.push_back(e);
  endtask

  // One clock edge; every increment of instret retires the oldest scoreboard entry
  task automatic tick();
    logic r;
    wb_t  e;
    r = rst;
    @(posedge clk);
    #1;
    if (!r && (instret !== prev_instret)) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", {27'd0, MEM_WB_Rd}, {27'd0, e.rd});
        chk("wb_regwrite", {31'd0, MEM_WB_RegWrite}, {31'd0, e.rw});
        chk("wb_wdata", MEM_WB_wdata, e.wdata);
      end
    end
    prev_instret = instret;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [2:0] f3, input logic [1:0] wbs,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc);
    ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_funct3 = f3; ex_wb_sel = wbs; ex_alu_result = alu; ex_store_data = sd; ex_pc = pc;
  endtask

  initial begin
    rst = 1'b1;
    flush_ex = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 3'b010, 2'b01, 32'hDEADBEEF, 32'h5A5A5A5A, 32'h1234);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'h12345678;
    tick();
    tick();
    chk("rst_exmem_rd", {27'd0, EX_MEM_Rd}, 32'd0);
    chk("rst_exmem_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("rst_exmem_alu", EX_MEM_alu_result, 32'd0);
    chk("rst_memwb_rd", {27'd0, MEM_WB_Rd}, 32'd0);
    chk("rst_memwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
    chk("rst_memwb_wdata", MEM_WB_wdata, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_re", {31'd0, bus.dmem_re}, 32'd0);
    chk("rst_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("rst_be", {28'd0, bus.dmem_be}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);

    rst = 1'b0;
    flush_ex = 1'b0;
    bus.dmem_ready = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 32'h10, 32'h0, 32'h0);
    push(5'd3, 1'b1, 32'h10);
    tick();
    chk("alu_exmem_rd", {27'd0, EX_MEM_Rd}, 32'd3);
    chk("alu_exmem_rw", {31'd0, EX_MEM_RegWrite}, 32'd1);
    chk("alu_exmem_val", EX_MEM_alu_result, 32'h10);
    chk("alu_instret0", instret, 32'd0);

    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 32'h55, 32'h0, 32'h0);
    push(5'd0, 1'b0, 32'h55);
    tick();
    chk("x0_exmem_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("alu_instret1", instret, 32'd1);

    bus.dmem_rdata = 32'h80112233;
    drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000, 2'b01, 32'h103, 32'h0, 32'h0);
    push(5'd5, 1'b1, 32'hFFFFFF80);
    tick();
    chk("x0_instret2", instret, 32'd2);
    chk("lb_addr", bus.dmem_addr, 32'h100);
    chk("lb_re", {31'd0, bus.dmem_re}, 32'd1);
    chk("lb_be", {28'd0, bus.dmem_be}, 32'd0);
    chk("lb_stall", {31'd0, mem_stall}, 32'd0);
    chk("lb_memread", {31'd0, EX_MEM_MemRead}, 32'd1);

    drive(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 3'b101, 2'b01, 32'h102, 32'h0, 32'h0);
    push(5'd6, 1'b1, 32'h00008011);
    tick();
    drive(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 3'b001, 2'b01, 32'h102, 32'h0, 32'h0);
    push(5'd4, 1'b1, 32'hFFFF8011);
    tick();
    drive(1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 3'b001, 2'b00, 32'h106, 32'h0000ABCD, 32'h0);
    push(5'd7, 1'b0, 32'h106);
    tick();
    chk("sh_be", {28'd0, bus.dmem_be}, 32'hC);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCDABCD);
    chk("sh_we", {31'd0, bus.dmem_we}, 32'd1);
    chk("sh_re", {31'd0, bus.dmem_re}, 32'd0);
    chk("sh_addr", bus.dmem_addr, 32'h104);

    drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 3'b010, 2'b10, 32'h999, 32'h0, 32'h200);
    push(5'd1, 1'b1, 32'h204);
    tick();
    chk("jal_be", {28'd0, bus.dmem_be}, 32'd0);
    chk("jal_we", {31'd0, bus.dmem_we}, 32'd0);

    drive(1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 32'h101, 32'h12345677, 32'h0);
    push(5'd2, 1'b0, 32'h101);
    tick();
    chk("sb_be", {28'd0, bus.dmem_be}, 32'h2);
    chk("sb_wdata", bus.dmem_wdata, 32'h77777777);

    flush_ex = 1'b1;
    drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 32'h33, 32'h0, 32'h0);
    tick();
    flush_ex = 1'b0;
    chk("flush_rd", {27'd0, EX_MEM_Rd}, 32'd0);
    chk("flush_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("flush_instret", instret, 32'd8);

    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'hDEADBEEF;
    drive(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h200, 32'h0, 32'h0);
    push(5'd9, 1'b1, 32'hCAFEF00D);
    tick();
    chk("stall_instret_pre", instret, 32'd8);
    chk("stall_c1", {31'd0, mem_stall}, 32'd1);
    chk("stall_addr", bus.dmem_addr, 32'h200);
    drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 32'h77, 32'h0, 32'h0);
    push(5'd10, 1'b1, 32'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {31'd0, mem_stall}, 32'd1);
      chk("stall_exmem_rd", {27'd0, EX_MEM_Rd}, 32'd9);
      chk("stall_memwb_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
      chk("stall_instret", instret, 32'd8);
      flush_ex = (i == 0);
    end
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("stall_release", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("ld_instret", instret, 32'd9);
    chk("post_stall_rd", {27'd0, EX_MEM_Rd}, 32'd10);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
    tick();
    chk("alu2_instret", instret, 32'd10);

    bus.dmem_ready = 1'b0;
    drive(1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01, 32'h300, 32'h0, 32'h0);
    tick();
    chk("rst2_pre_stall", {31'd0, mem_stall}, 32'd1);
    rst = 1'b1;
    ex_valid = 1'b0;
    tick();
    chk("rst2_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst2_re", {31'd0, bus.dmem_re}, 32'd0);
    chk("rst2_be", {28'd0, bus.dmem_be}, 32'd0);
    chk("rst2_instret", instret, 32'd0);
    chk("rst2_exmem_rd", {27'd0, EX_MEM_Rd}, 32'd0);
    chk("rst2_exmem_alu", EX_MEM_alu_result, 32'd0);
    chk("rst2_memwb_rd", {27'd0, MEM_WB_Rd}, 32'd0);
    chk("rst2_memwb_wdata", MEM_WB_wdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst2_after_instret", instret, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
